tlp_tx_arb: RTL and testbench

TLP_TX_ARB -- requirements
Module: tlp_tx_arb

---
 rtl/tlp_tx_arb.sv | 123 ++++++++++++
 tb/tb_tlp_tx_arb.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlp_tx_arb.sv
// Round-robin TLP arbiter merging write and read request paths onto one link,
// gated by a saturating posted/non-posted header credit counter.
module tlp_tx_arb #(
  parameter int DATA_W      = 32,
  parameter int CREDIT_W    = 3,
  parameter int CREDIT_INIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [DATA_W-1:0]   wr_data_i,
  input  logic                wr_valid_i,
  input  logic                wr_last_i,
  output logic                wr_ready_o,
  input  logic [DATA_W-1:0]   rd_data_i,
  input  logic                rd_valid_i,
  input  logic                rd_last_i,
  output logic                rd_ready_o,
  output logic [DATA_W-1:0]   tlp_data_o,
  output logic                tlp_valid_o,
  output logic                tlp_last_o,
  input  logic                tlp_ready_i,
  input  logic                credit_ret_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic [1:0]          grant_o,
  output logic                credit_err_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_WR = 2'd1,
    GNT_RD = 2'd2
  } state_e;

  localparam logic [CREDIT_W-1:0] CMAX = CREDIT_W'(CREDIT_INIT);
  localparam logic [CREDIT_W-1:0] ONE  = CREDIT_W'(1);

  state_e              state_q, state_d;
  logic                last_rd_q, last_rd_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                err_q, err_d;
  logic                take;
  logic                pick_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_rd_q <= 1'b1;
      credit_q  <= CMAX;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      credit_q  <= credit_d;
      err_q     <= err_d;
    end
  end

  // Write wins unless read is also waiting and write was served last.
  assign pick_wr = wr_valid_i & (~rd_valid_i | last_rd_q);

  always_comb begin
    state_d     = state_q;
    last_rd_d   = last_rd_q;
    take        = 1'b0;
    tlp_data_o  = '0;
    tlp_valid_o = 1'b0;
    tlp_last_o  = 1'b0;
    wr_ready_o  = 1'b0;
    rd_ready_o  = 1'b0;
    grant_o     = 2'b00;
    case (state_q)
      IDLE: begin
        if ((credit_q != '0) && (wr_valid_i || rd_valid_i)) begin
          take      = 1'b1;
          state_d   = pick_wr ? GNT_WR : GNT_RD;
          last_rd_d = ~pick_wr;
        end
      end
      GNT_WR: begin
        grant_o     = 2'b01;
        tlp_data_o  = wr_data_i;
        tlp_valid_o = wr_valid_i;
        tlp_last_o  = wr_last_i;
        wr_ready_o  = tlp_ready_i;
        if (wr_valid_i && wr_last_i && tlp_ready_i) begin
          state_d = IDLE;
        end
      end
      GNT_RD: begin
        grant_o     = 2'b10;
        tlp_data_o  = rd_data_i;
        tlp_valid_o = rd_valid_i;
        tlp_last_o  = rd_last_i;
        rd_ready_o  = tlp_ready_i;
        if (rd_valid_i && rd_last_i && tlp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A return into a full counter is dropped and flagged.
  always_comb begin
    credit_d = credit_q;
    err_d    = err_q;
    case ({take, credit_ret_i})
      2'b10: credit_d = credit_q - ONE;
      2'b01: begin
        if (credit_q == CMAX) begin
          err_d = 1'b1;
        end else begin
          credit_d = credit_q + ONE;
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  assign credit_o     = credit_q;
  assign credit_err_o = err_q;

endmodule

// File: tb/tb_tlp_tx_arb.sv
// Bench for tlp_tx_arb: vector table, corner sequences and a
// randomized run against a cycle-level behavioural model.
module tb_tlp_tx_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wr_data_i, rd_data_i;
  logic        wr_valid_i, wr_last_i, rd_valid_i, rd_last_i;
  logic        wr_ready_o, rd_ready_o;
  logic [31:0] tlp_data_o;
  logic        tlp_valid_o, tlp_last_o, tlp_ready_i, credit_ret_i;
  logic [2:0]  credit_o;
  logic [1:0]  grant_o;
  logic        credit_err_o;

  int total = 0;
  int bad   = 0;

  tlp_tx_arb #(.DATA_W(32), .CREDIT_W(3), .CREDIT_INIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_data_i(wr_data_i), .wr_valid_i(wr_valid_i),
    .wr_last_i(wr_last_i), .wr_ready_o(wr_ready_o),
    .rd_data_i(rd_data_i), .rd_valid_i(rd_valid_i),
    .rd_last_i(rd_last_i), .rd_ready_o(rd_ready_o),
    .tlp_data_o(tlp_data_o), .tlp_valid_o(tlp_valid_o),
    .tlp_last_o(tlp_last_o), .tlp_ready_i(tlp_ready_i),
    .credit_ret_i(credit_ret_i), .credit_o(credit_o),
    .grant_o(grant_o), .credit_err_o(credit_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wl, rl, ret;
    logic [1:0]  g;
    logic        wrr, rdr, v, l;
    logic [2:0]  cr;
  } vec_t;

  vec_t tbl[13];

  function automatic vec_t mk(input logic wl, rl, ret,
                              input logic [1:0] g,
                              input logic wrr, rdr, v, l,
                              input logic [2:0] cr);
    vec_t r;
    r.wl = wl; r.rl = rl; r.ret = ret; r.g = g;
    r.wrr = wrr; r.rdr = rdr; r.v = v; r.l = l; r.cr = cr;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    wr_valid_i = 0; wr_last_i = 0; wr_data_i = '0;
    rd_valid_i = 0; rd_last_i = 0; rd_data_i = '0;
    tlp_ready_i = 1; credit_ret_i = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  // behavioural model: owner 0 none, 1 write, 2 read
  int m_own, m_cred, m_err, m_last_rd;

  initial begin
    int got, seen;
    int wv, wl, rv, rl, tr, ret, pick, tk;
    logic [31:0] wd, rd, ed;

    // REQ-034/037 path: both valid, 3-dword TLPs, ret on a take cycle
    tbl[0]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 3'd4);
    tbl[1]  = mk(0, 0, 0, 2'b01, 1, 0, 1, 0, 3'd3);
    tbl[2]  = mk(0, 0, 0, 2'b01, 1, 0, 1, 0, 3'd3);
    tbl[3]  = mk(1, 0, 0, 2'b01, 1, 0, 1, 1, 3'd3);
    tbl[4]  = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 3'd3);
    tbl[5]  = mk(0, 0, 0, 2'b10, 0, 1, 1, 0, 3'd2);
    tbl[6]  = mk(0, 0, 0, 2'b10, 0, 1, 1, 0, 3'd2);
    tbl[7]  = mk(0, 1, 0, 2'b10, 0, 1, 1, 1, 3'd2);
    tbl[8]  = mk(0, 0, 1, 2'b00, 0, 0, 0, 0, 3'd2);
    tbl[9]  = mk(0, 0, 0, 2'b01, 1, 0, 1, 0, 3'd2);
    tbl[10] = mk(1, 0, 0, 2'b01, 1, 0, 1, 1, 3'd2);
    tbl[11] = mk(0, 0, 0, 2'b00, 0, 0, 0, 0, 3'd2);
    tbl[12] = mk(0, 1, 0, 2'b10, 0, 1, 1, 1, 3'd1);

    do_reset();
    @(negedge clk);
    chk("rst_grant", 32'(grant_o), 0);
    chk("rst_credit", 32'(credit_o), 4);
    chk("rst_err", 32'(credit_err_o), 0);
    chk("rst_valid", 32'(tlp_valid_o), 0);
    chk("rst_ready", 32'({wr_ready_o, rd_ready_o}), 0);
    step();

    for (int i = 0; i < 13; i++) begin
      wr_valid_i = 1; wr_last_i = tbl[i].wl;
      wr_data_i = 32'hA000_0000 + 32'(i);
      rd_valid_i = 1; rd_last_i = tbl[i].rl;
      rd_data_i = 32'hB000_0000 + 32'(i);
      tlp_ready_i = 1; credit_ret_i = tbl[i].ret;
      @(negedge clk);
      chk($sformatf("t%0d_grant", i), 32'(grant_o), 32'(tbl[i].g));
      chk($sformatf("t%0d_wrrdy", i), 32'(wr_ready_o), 32'(tbl[i].wrr));
      chk($sformatf("t%0d_rdrdy", i), 32'(rd_ready_o), 32'(tbl[i].rdr));
      chk($sformatf("t%0d_valid", i), 32'(tlp_valid_o), 32'(tbl[i].v));
      chk($sformatf("t%0d_last", i), 32'(tlp_last_o), 32'(tbl[i].l));
      chk($sformatf("t%0d_credit", i), 32'(credit_o), 32'(tbl[i].cr));
      if (tbl[i].g != 2'b00) begin
        ed = (tbl[i].g == 2'b01) ? wr_data_i : rd_data_i;
        chk($sformatf("t%0d_data", i), tlp_data_o, ed);
      end
      step();
    end

    // credit exhaustion with single-dword write TLPs
    do_reset();
    wr_valid_i = 1; wr_last_i = 1; wr_data_i = 32'h1111_0000;
    got = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (grant_o == 2'b01) got++;
      step();
    end
    @(negedge clk);
    chk("exh_grants", 32'(got), 4);
    chk("exh_credit", 32'(credit_o), 0);
    chk("exh_idle", 32'(grant_o), 0);
    step();
    credit_ret_i = 1;
    step();
    credit_ret_i = 0;
    seen = 0;
    for (int c = 0; c < 3 && seen == 0; c++) begin
      @(negedge clk);
      if (grant_o == 2'b01) seen = 1;
      step();
    end
    chk("exh_regrant", 32'(seen), 1);
    @(negedge clk);
    chk("exh_credit2", 32'(credit_o), 0);
    step();

    // downstream stall mid-TLP
    do_reset();
    wr_valid_i = 1; wr_last_i = 0; wr_data_i = 32'hD1;
    rd_valid_i = 1; rd_data_i = 32'hEE;
    step();
    step();
    wr_data_i = 32'hD2; tlp_ready_i = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("stall%0d_data", c), tlp_data_o, 32'hD2);
      chk($sformatf("stall%0d_wrrdy", c), 32'(wr_ready_o), 0);
      chk($sformatf("stall%0d_rdrdy", c), 32'(rd_ready_o), 0);
      chk($sformatf("stall%0d_grant", c), 32'(grant_o), 1);
      step();
    end
    tlp_ready_i = 1; wr_last_i = 1;
    @(negedge clk);
    chk("stall_resume", 32'(wr_ready_o), 1);
    step();
    wr_valid_i = 0; wr_last_i = 0;
    step();
    @(negedge clk);
    chk("stall_rd_next", 32'(grant_o), 2);
    step();

    // return into a full counter
    do_reset();
    credit_ret_i = 1;
    step();
    credit_ret_i = 0;
    @(negedge clk);
    chk("ovf_credit", 32'(credit_o), 4);
    chk("ovf_err", 32'(credit_err_o), 1);
    step();
    step();
    @(negedge clk);
    chk("ovf_sticky", 32'(credit_err_o), 1);
    do_reset();
    @(negedge clk);
    chk("ovf_clr", 32'(credit_err_o), 0);
    step();

    // async reset during beat 2 of a read TLP
    do_reset();
    rd_valid_i = 1; rd_last_i = 0; rd_data_i = 32'hCC;
    step();
    step();
    @(negedge clk);
    chk("ar_pre_grant", 32'(grant_o), 2);
    #2 rst_n = 0;
    #1;
    chk("ar_grant", 32'(grant_o), 0);
    chk("ar_valid", 32'(tlp_valid_o), 0);
    chk("ar_rdrdy", 32'(rd_ready_o), 0);
    chk("ar_credit", 32'(credit_o), 4);
    wr_valid_i = 1; wr_last_i = 1;
    step();
    rst_n = 1;
    @(negedge clk);
    chk("ar_no_beat", 32'(tlp_valid_o), 0);
    step();
    @(negedge clk);
    chk("ar_wr_wins", 32'(grant_o), 1);
    step();

    // randomized run against the model
    do_reset();
    m_own = 0; m_cred = 4; m_err = 0; m_last_rd = 1;
    for (int c = 0; c < 3000; c++) begin
      wv = ($urandom_range(0, 3) != 0);
      wl = ($urandom_range(0, 3) == 0);
      rv = ($urandom_range(0, 3) != 0);
      rl = ($urandom_range(0, 3) == 0);
      tr = ($urandom_range(0, 3) != 0);
      ret = ($urandom_range(0, 6) == 0);
      wd = $urandom; rd = $urandom;
      wr_valid_i = wv[0]; wr_last_i = wl[0]; wr_data_i = wd;
      rd_valid_i = rv[0]; rd_last_i = rl[0]; rd_data_i = rd;
      tlp_ready_i = tr[0]; credit_ret_i = ret[0];
      @(negedge clk);
      chk("rnd_grant", 32'(grant_o), (m_own == 1) ? 1 : (m_own == 2) ? 2 : 0);
      chk("rnd_credit", 32'(credit_o), 32'(m_cred));
      chk("rnd_err", 32'(credit_err_o), 32'(m_err));
      chk("rnd_wrrdy", 32'(wr_ready_o), 32'(m_own == 1 && tr == 1));
      chk("rnd_rdrdy", 32'(rd_ready_o), 32'(m_own == 2 && tr == 1));
      chk("rnd_valid", 32'(tlp_valid_o),
          (m_own == 1) ? 32'(wv) : (m_own == 2) ? 32'(rv) : 0);
      if (m_own != 0) begin
        chk("rnd_data", tlp_data_o, (m_own == 1) ? wd : rd);
        chk("rnd_last", 32'(tlp_last_o), (m_own == 1) ? 32'(wl) : 32'(rl));
      end
      tk = 0;
      if (m_own == 0) begin
        if (m_cred > 0 && (wv == 1 || rv == 1)) begin
          tk = 1;
          if (wv == 1 && rv == 1) pick = m_last_rd ? 1 : 2;
          else pick = (wv == 1) ? 1 : 2;
          m_own = pick;
          m_last_rd = (pick == 2);
        end
      end else if (tr == 1) begin
        if (m_own == 1 && wv == 1 && wl == 1) m_own = 0;
        else if (m_own == 2 && rv == 1 && rl == 1) m_own = 0;
      end
      m_cred = m_cred - tk + ret;
      if (m_cred > 4) begin
        m_cred = 4;
        m_err = 1;
      end
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
